lighting_next_state_logic: RTL and testbench

//   Next-state and output logic for the automatic-lighting controller.

---
 rtl/lighting_next_state_logic.sv | 133 +++++++++++++
 tb/tb_lighting_next_state_logic.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lighting_next_state_logic.sv
// Next-state and registered lamp-output logic for the automatic-lighting controller.
// Also synchronises and debounces the PIR sensor and times the HOLD and DIM dwell periods.
module lighting_next_state_logic #(
   parameter int HOLD_CYCLES     = 1000,
   parameter int DIM_CYCLES      = 500,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMER_W         = 16
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [1:0] Present_State,
   input  logic       Motion_Raw,
   input  logic       Dark,
   input  logic       Override,
   output logic [1:0] Next_State,
   output logic       Lamp_On,
   output logic       Lamp_Dim,
   output logic       Timeout_Pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ON   = 2'b01,
      ST_HOLD = 2'b10,
      ST_DIM  = 2'b11
   } state_t;

   state_t             present_st;
   state_t             next_st;
   logic               sync1;
   logic               sync2;
   logic               motion_db;
   logic [CNT_W-1:0]   db_cnt;
   logic [TIMER_W-1:0] timer;
   logic               timer_zero;
   logic               timeout_cause;

   assign present_st = state_t'(Present_State);
   assign Next_State = next_st;
   assign timer_zero = (timer == '0);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= Motion_Raw;
         sync2 <= sync1;
      end
   end

   // Motion_Db only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         motion_db <= 1'b0;
         db_cnt    <= '0;
      end else if (sync2 != motion_db) begin
         if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            motion_db <= ~motion_db;
            db_cnt    <= '0;
         end else begin
            db_cnt <= db_cnt + CNT_W'(1);
         end
      end else begin
         db_cnt <= '0;
      end
   end

   always_comb begin
      next_st       = present_st;
      timeout_cause = 1'b0;
      if (Reset) begin
         next_st = ST_IDLE;
      end else if (Override) begin
         next_st = ST_ON;
      end else begin
         case (present_st)
            ST_IDLE: next_st = (Dark && motion_db) ? ST_ON : ST_IDLE;
            ST_ON: begin
               if (!Dark)            next_st = ST_IDLE;
               else if (!motion_db)  next_st = ST_HOLD;
            end
            ST_HOLD: begin
               if (!Dark)            next_st = ST_IDLE;
               else if (motion_db)   next_st = ST_ON;
               else if (timer_zero) begin
                  next_st       = ST_DIM;
                  timeout_cause = 1'b1;
               end
            end
            ST_DIM: begin
               if (!Dark)            next_st = ST_IDLE;
               else if (motion_db)   next_st = ST_ON;
               else if (timer_zero) begin
                  next_st       = ST_IDLE;
                  timeout_cause = 1'b1;
               end
            end
            default: next_st = ST_IDLE;
         endcase
      end
   end

   // Loading N-1 on entry makes the dwell exactly N cycles, since the exit fires on zero.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         timer <= '0;
      end else if (next_st != present_st) begin
         case (next_st)
            ST_HOLD: timer <= TIMER_W'(HOLD_CYCLES - 1);
            ST_DIM:  timer <= TIMER_W'(DIM_CYCLES - 1);
            default: timer <= '0;
         endcase
      end else if (!timer_zero) begin
         timer <= timer - TIMER_W'(1);
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Lamp_On       <= 1'b0;
         Lamp_Dim      <= 1'b0;
         Timeout_Pulse <= 1'b0;
      end else begin
         Lamp_On       <= (next_st == ST_ON) || (next_st == ST_HOLD);
         Lamp_Dim      <= (next_st == ST_DIM);
         Timeout_Pulse <= timeout_cause;
      end
   end

endmodule

// File: tb/tb_lighting_next_state_logic.sv
// Bench for lighting_next_state_logic: closes the loop with a 2-bit state register and
// compares every cycle against a dwell-counting reference model of the lighting rules.
module tb_lighting_next_state_logic;

   localparam int HOLD_C = 8;
   localparam int DIM_C  = 4;
   localparam int DEB_C  = 2;
   localparam int M_IDLE = 0, M_ON = 1, M_HOLD = 2, M_DIM = 3;

   logic       Clock;
   logic       Reset;
   logic [1:0] present_state;
   logic       motion_raw;
   logic       dark;
   logic       override_sw;
   logic [1:0] next_state;
   logic       lamp_on;
   logic       lamp_dim;
   logic       timeout_pulse;

   int tests  = 0;
   int failed = 0;

   // reference model state
   int m_state, m_dwell, m_streak;
   bit m_s1, m_s2, m_db, m_on, m_dim, m_pulse;

   lighting_next_state_logic #(
      .HOLD_CYCLES(HOLD_C), .DIM_CYCLES(DIM_C), .DEBOUNCE_CYCLES(DEB_C), .TIMER_W(16)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Present_State(present_state),
      .Motion_Raw(motion_raw), .Dark(dark), .Override(override_sw),
      .Next_State(next_state), .Lamp_On(lamp_on), .Lamp_Dim(lamp_dim),
      .Timeout_Pulse(timeout_pulse)
   );

   // controller's state register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) present_state <= 2'b00;
      else       present_state <= next_state;
   end

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // The rules as a table over "edges spent in the current state".
   function automatic void model_next(output int nxt, output bit tmo);
      bit expired;
      expired = (m_state == M_HOLD && m_dwell >= HOLD_C - 1) ||
                (m_state == M_DIM  && m_dwell >= DIM_C - 1);
      tmo = 1'b0;
      nxt = m_state;
      if (override_sw) nxt = M_ON;
      else if (m_state == M_IDLE) nxt = (dark && m_db) ? M_ON : M_IDLE;
      else if (!dark) nxt = M_IDLE;
      else if (m_state == M_ON) nxt = m_db ? M_ON : M_HOLD;
      else if (m_db) nxt = M_ON;
      else if (expired) begin
         nxt = (m_state == M_HOLD) ? M_DIM : M_IDLE;
         tmo = 1'b1;
      end
   endfunction

   task automatic model_reset();
      m_state = M_IDLE; m_dwell = 0; m_streak = 0;
      m_s1 = 0; m_s2 = 0; m_db = 0; m_on = 0; m_dim = 0; m_pulse = 0;
   endtask

   // Called at a negedge; drives inputs, checks, crosses one posedge, ends at the next negedge.
   task automatic step(input bit r, input bit d, input bit o);
      int nxt;
      bit tmo;
      motion_raw = r; dark = d; override_sw = o;
      #1;
      model_next(nxt, tmo);
      check_eq("next_state", 32'(next_state), 32'(nxt));
      check_eq("present_state", 32'(present_state), 32'(m_state));
      check_eq("lamp_on", 32'(lamp_on), 32'(m_on));
      check_eq("lamp_dim", 32'(lamp_dim), 32'(m_dim));
      check_eq("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
      @(posedge Clock);
      m_on    = (nxt == M_ON) || (nxt == M_HOLD);
      m_dim   = (nxt == M_DIM);
      m_pulse = tmo;
      m_dwell = (nxt == m_state) ? m_dwell + 1 : 0;
      m_state = nxt;
      if (m_s2 != m_db) begin
         m_streak++;
         if (m_streak == DEB_C) begin
            m_db = ~m_db;
            m_streak = 0;
         end
      end else begin
         m_streak = 0;
      end
      m_s2 = m_s1;
      m_s1 = r;
      @(negedge Clock);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      #1;
      check_eq("rst_next_state", 32'(next_state), 32'd0);
      check_eq("rst_lamp_on", 32'(lamp_on), 32'd0);
      check_eq("rst_lamp_dim", 32'(lamp_dim), 32'd0);
      check_eq("rst_timeout", 32'(timeout_pulse), 32'd0);
      model_reset();
      @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
   endtask

   task automatic repeat_step(input int n, input bit r, input bit d, input bit o);
      for (int i = 0; i < n; i++) step(r, d, o);
   endtask

   initial begin
      int hold_n, dim_n, pulse_n, seg, rv;
      bit dv, ov;
      Reset = 1'b1; motion_raw = 0; dark = 0; override_sw = 0;
      model_reset();
      @(negedge Clock);
      @(negedge Clock);
      do_reset();

      // motion detected in the dark: ON after five edges
      step(0, 1, 0);
      repeat_step(5, 1, 1, 0);
      check_eq("s1_present_on", 32'(present_state), 32'd1);
      check_eq("s1_lamp_on", 32'(lamp_on), 32'd1);

      // motion stops: full HOLD, full DIM, two timeout pulses, lamps off
      hold_n = 0; dim_n = 0; pulse_n = 0;
      for (int i = 0; i < 30; i++) begin
         step(0, 1, 0);
         if (present_state == 2'd2) hold_n++;
         if (present_state == 2'd3) dim_n++;
         if (timeout_pulse) pulse_n++;
      end
      check_eq("s2_hold_len", 32'(hold_n), 32'(HOLD_C));
      check_eq("s2_dim_len", 32'(dim_n), 32'(DIM_C));
      check_eq("s2_pulses", 32'(pulse_n), 32'd2);
      check_eq("s2_idle", 32'(present_state), 32'd0);
      check_eq("s2_lamps", 32'({lamp_on, lamp_dim}), 32'd0);

      // one-cycle glitch is filtered
      step(1, 1, 0);
      repeat_step(8, 0, 1, 0);
      check_eq("s3_idle", 32'(present_state), 32'd0);

      // motion returning at every point of HOLD, including the cycle the timer expires
      for (int off = 0; off < 16; off++) begin
         do_reset();
         repeat_step(7, 1, 1, 0);
         repeat_step(off, 0, 1, 0);
         repeat_step(10, 1, 1, 0);
         repeat_step(2, 0, 1, 0);
      end

      // override in daylight, then release
      do_reset();
      repeat_step(3, 0, 0, 1);
      check_eq("s5_override_on", 32'(present_state), 32'd1);
      step(0, 0, 0);
      check_eq("s5_release_idle", 32'(present_state), 32'd0);

      // reset in the middle of DIM, then normal operation
      do_reset();
      repeat_step(7, 1, 1, 0);
      repeat_step(14, 0, 1, 0);
      check_eq("s6_in_dim", 32'(present_state), 32'd3);
      do_reset();
      check_eq("s6_present_cleared", 32'(present_state), 32'd0);
      check_eq("s6_timer_cleared", 32'(dut.timer), 32'd0);
      repeat_step(6, 1, 1, 0);
      check_eq("s6_back_on", 32'(present_state), 32'd1);

      // random segments: motion held for random lengths, mostly dark, rare override
      for (int n = 0; n < 250; n++) begin
         seg = $urandom_range(1, 16);
         rv  = $urandom_range(0, 1);
         dv  = ($urandom_range(0, 7) != 0);
         ov  = ($urandom_range(0, 15) == 0);
         repeat_step(seg, rv[0], dv, ov);
         if ($urandom_range(0, 60) == 0) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
